mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Sequences and shares the single-port data memory of the MEM2 stage between two requesters:
//  the pipeline (MEM_R_EN/MEM_W_EN path) and a loader/debug port.
//  Inserts configurable memory wait states and freezes the pipeline until its access completes.
//  Sits between MEM2 stage control/data and the dataMem2 instance.
// PARAMETERS
//  WAIT_STATES   1  extra cycles per access; an access occupies WAIT_STATES+1 BUSY cycles
//  STARVE_LIMIT  8  consecutive pipeline grants before the loader is forced in (fairness only)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   reset, asynchronous, active-low
//  pipe_r_en    in   1   pipeline load request
//  pipe_w_en    in   1   pipeline store request
//  pipe_addr    in   32  pipeline final address
//  pipe_wdata   in   32  pipeline store value
//  pipe_rdata   out  32  pipeline load data
//  pipe_freeze  out  1   stall pipeline (combinational)
//  ldr_req      in   1   loader request, held until ldr_gnt
//  ldr_we       in   1   loader write (1) / read (0)
//  ldr_addr     in   32  loader address
//  ldr_wdata    in   32  loader write data
//  ldr_gnt      out  1   1-cycle pulse: loader request accepted
//  ldr_done     out  1   1-cycle pulse: loader access complete
//  ldr_rdata    out  32  loader read data, held until next loader read completes
//  mem_r_en     out  1   to dataMem2 readEn
//  mem_w_en     out  1   to dataMem2 writeEn
//  mem_addr     out  32  to dataMem2 finaladdress
//  mem_wdata    out  32  to dataMem2 dataIn
//  mem_rdata    in   32  from dataMem2 dataOut, valid in last BUSY cycle
// BEHAVIOUR
//  - Reset (rst=0): state IDLE, wait counter 0, all outputs 0; in-flight access abandoned,
//    mem_r_en/mem_w_en drop immediately; no ldr_done for the abandoned access.
//  - FSM IDLE/BUSY. IDLE: arbitrate; if pipe_r_en|pipe_w_en -> grant PIPE, else if ldr_req ->
//    grant LDR (ldr_gnt=1 this cycle); latch owner, addr, wdata, write flag; cnt<=WAIT_STATES; ->BUSY.
//  - pipe_r_en & pipe_w_en both high: treated as write.
//  - BUSY: mem_addr/mem_wdata from latches; mem_w_en=write flag, mem_r_en=~write flag; cnt
//    decrements each cycle; cycle with cnt==0 is the completion cycle -> IDLE next edge.
//  - Arbitration only in IDLE; one IDLE cycle between consecutive accesses, always.
//  - Pipe priority: simultaneous pipe and ldr_req -> pipe wins (unless fairness forces loader).
//  - pipe_freeze = (pipe_r_en|pipe_w_en) & ~(BUSY & owner==PIPE & cnt==0).
//    Pipe access latency WAIT_STATES+2 cycles; freeze high WAIT_STATES+1 cycles.
//    Pipe request arriving while loader is BUSY stays frozen until loader done, then arbitrated.
//  - pipe_rdata = mem_rdata in pipe read completion cycle, else last captured pipe read value.
//  - ldr_done pulses in loader completion cycle; ldr_rdata registered from mem_rdata on that edge.
//  - Request inputs are sampled only in IDLE; changes during BUSY are ignored.
// CONFIGURATION
//  ARB_FAIRNESS_EN defined: starve counter increments on each PIPE grant while ldr_req=1,
//    clears when ldr_req=0 or on LDR grant; when counter==STARVE_LIMIT, next IDLE grants LDR
//    even if pipe requests (pipe stays frozen).
//  Not defined: strict pipe priority, no starve counter, STARVE_LIMIT unused.
// TESTING
//  1 rst=0 mid-run -> all outputs 0, pipe_freeze=0; after release first request granted from IDLE.
//  2 WAIT_STATES=1, pipe_r_en addr 0x10, mem_rdata=0xDEADBEEF -> freeze high 2 cycles,
//    mem_r_en high 2 cycles, pipe_rdata=0xDEADBEEF in 3rd cycle, freeze 0 there.
//  3 pipe_w_en (addr 0x20, data 0x5) and ldr_req same cycle -> pipe write first;
//    ldr_gnt pulses in IDLE after pipe done.
//  4 ldr read addr 0x40, no pipe traffic -> ldr_gnt 1 cycle, mem_r_en WAIT_STATES+1 cycles,
//    ldr_done 1 cycle, ldr_rdata held.
//  5 rst=0 during loader BUSY -> mem_*_en low same cycle, ldr_done never pulses.
//  6 ARB_FAIRNESS_EN, STARVE_LIMIT=2, continuous pipe requests, ldr_req held ->
//    ldr_gnt after 2 pipe accesses; without the macro ldr_gnt never asserts.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Shares the MEM2 single-port data memory between the pipeline and a loader/debug port,
// inserting WAIT_STATES per access. Define ARB_FAIRNESS_EN to enable loader anti-starvation.
module mem_access_arbiter #(
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_r_en,
  input  logic        pipe_w_en,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  output logic [31:0] pipe_rdata,
  output logic        pipe_freeze,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic        ldr_gnt,
  output logic        ldr_done,
  output logic [31:0] ldr_rdata,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_PIPE, OWN_LDR} owner_t;

  localparam int CNT_W = $clog2(WAIT_STATES + 2);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);

  if (WAIT_STATES < 0 || STARVE_LIMIT < 1) begin : g_bad_params
    $error("mem_access_arbiter: WAIT_STATES must be >= 0 and STARVE_LIMIT >= 1");
  end

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [31:0]      pipe_rdata_q, pipe_rdata_d;
  logic [31:0]      ldr_rdata_q, ldr_rdata_d;

  logic pipe_req;
  logic grant_pipe;
  logic grant_ldr;
  logic done;
  logic force_ldr;

  assign pipe_req = pipe_r_en | pipe_w_en;

`ifdef ARB_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;

  // Counts pipe grants that jumped a waiting loader; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!ldr_req || grant_ldr) begin
      starve_d = '0;
    end else if (grant_pipe && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign force_ldr = ldr_req && (starve_q == STARVE_MAX);
`else
  assign force_ldr = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    pipe_rdata_d = pipe_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    grant_pipe   = 1'b0;
    grant_ldr    = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (pipe_req && !force_ldr) begin
          grant_pipe = 1'b1;
          owner_d    = OWN_PIPE;
          addr_d     = pipe_addr;
          wdata_d    = pipe_wdata;
          we_d       = pipe_w_en;
        end else if (ldr_req) begin
          grant_ldr  = 1'b1;
          owner_d    = OWN_LDR;
          addr_d     = ldr_addr;
          wdata_d    = ldr_wdata;
          we_d       = ldr_we;
        end
        if (grant_pipe || grant_ldr) begin
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Read data from the memory is only valid in the final BUSY cycle.
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
          if (!we_q) begin
            if (owner_q == OWN_PIPE) begin
              pipe_rdata_d = mem_rdata;
            end else begin
              ldr_rdata_d  = mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_PIPE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      pipe_rdata_q <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      pipe_rdata_q <= pipe_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  // Request-driven outputs are gated by rst so they read 0 while reset is held.
  assign mem_r_en    = (state_q == BUSY) && !we_q;
  assign mem_w_en    = (state_q == BUSY) && we_q;
  assign mem_addr    = (state_q == BUSY) ? addr_q  : '0;
  assign mem_wdata   = (state_q == BUSY) ? wdata_q : '0;
  assign pipe_freeze = rst && pipe_req && !(done && (owner_q == OWN_PIPE));
  assign pipe_rdata  = (done && (owner_q == OWN_PIPE) && !we_q) ? mem_rdata : pipe_rdata_q;
  assign ldr_gnt     = rst && grant_ldr;
  assign ldr_done    = done && (owner_q == OWN_LDR);
  assign ldr_rdata   = ldr_rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed vector table, reset/fairness sequences and a
// randomized run checked against a cycle-level reference model.
module tb_mem_access_arbiter;

  localparam int WS = 1;
  localparam int SL = 2;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_r_en, pipe_w_en;
  logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
  logic        pipe_freeze;
  logic        ldr_req, ldr_we;
  logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic        ldr_gnt, ldr_done;
  logic        mem_r_en, mem_w_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  assign mem_rdata = memfn(mem_addr);

  mem_access_arbiter #(.WAIT_STATES(WS), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .pipe_r_en(pipe_r_en), .pipe_w_en(pipe_w_en), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_freeze(pipe_freeze),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: remaining BUSY cycles of the current access (0 = idle).
  int          m_left = 0;
  int          m_starve = 0;
  bit          m_own_pipe, m_we, m_last_gl;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_prd = '0;
  logic [31:0] m_lrd = '0;

  task automatic model_step(input string tag);
    logic        frz, mr, mw, gnt, dn;
    logic [31:0] ma, md, prd, lrd;
    bit          preq, force_l, gp, gl, last;
    preq = pipe_r_en | pipe_w_en;
    frz = 0; mr = 0; mw = 0; gnt = 0; dn = 0; ma = '0; md = '0;
    prd = m_prd; lrd = m_lrd; gp = 0; gl = 0; last = 0;
    if (!rst) begin
      prd = '0;
      lrd = '0;
    end else if (m_left == 0) begin
      force_l = FAIR && ldr_req && (m_starve >= SL);
      gp  = preq && !force_l;
      gl  = !gp && ldr_req;
      frz = preq;
      gnt = gl;
    end else begin
      last = (m_left == 1);
      mr = !m_we; mw = m_we; ma = m_addr; md = m_wdata;
      frz = preq && !(last && m_own_pipe);
      dn  = last && !m_own_pipe;
      if (last && m_own_pipe && !m_we) prd = memfn(m_addr);
    end
    chk({tag, ".freeze"}, pipe_freeze, frz);
    chk({tag, ".mem_r_en"}, mem_r_en, mr);
    chk({tag, ".mem_w_en"}, mem_w_en, mw);
    chk({tag, ".mem_addr"}, mem_addr, ma);
    chk({tag, ".mem_wdata"}, mem_wdata, md);
    chk({tag, ".ldr_gnt"}, ldr_gnt, gnt);
    chk({tag, ".ldr_done"}, ldr_done, dn);
    chk({tag, ".pipe_rdata"}, pipe_rdata, prd);
    chk({tag, ".ldr_rdata"}, ldr_rdata, lrd);
    m_last_gl = gl;
    if (!rst) begin
      m_left = 0; m_starve = 0; m_prd = '0; m_lrd = '0;
    end else begin
      if (gp || gl) begin
        m_own_pipe = gp;
        m_we    = gp ? pipe_w_en  : ldr_we;
        m_addr  = gp ? pipe_addr  : ldr_addr;
        m_wdata = gp ? pipe_wdata : ldr_wdata;
        m_left  = WS + 1;
      end else if (m_left > 0) begin
        if (last && !m_we) begin
          if (m_own_pipe) m_prd = memfn(m_addr);
          else            m_lrd = memfn(m_addr);
        end
        m_left--;
      end
      if (!ldr_req || gl)             m_starve = 0;
      else if (gp && m_starve < SL)   m_starve++;
    end
  endtask

  // Called at the falling edge: check against the model, then move to just after the rising edge.
  task automatic finish_cycle(input string tag);
    model_step(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    finish_cycle(tag);
  endtask

  task automatic idle_inputs();
    pipe_r_en = 0; pipe_w_en = 0; pipe_addr = '0; pipe_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
  endtask

  typedef struct {
    logic        pr, pw;
    logic [31:0] pa, pd;
    logic        lr, lw;
    logic [31:0] la, ld;
    logic        e_frz, e_mr, e_mw, e_gnt, e_done;
    logic [31:0] e_ma, e_prd, e_lrd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int seen;
    int first_gnt;
    rst = 0;
    idle_inputs();

    tbl[0]  = '{1, 0, 32'h10, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0,     0,            0};
    tbl[1]  = '{1, 0, 32'h10, 0, 0, 0, 0,     0, 1, 1, 0, 0, 0, 32'h10, 0,           0};
    tbl[2]  = '{1, 0, 32'h10, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 0};
    tbl[3]  = '{0, 1, 32'h20, 5, 1, 0, 32'h40, 0, 1, 0, 0, 0, 0, 0,     32'hDEADBEEF, 0};
    tbl[4]  = '{0, 1, 32'h20, 5, 1, 0, 32'h40, 0, 1, 0, 1, 0, 0, 32'h20, 32'hDEADBEEF, 0};
    tbl[5]  = '{0, 1, 32'h20, 5, 1, 0, 32'h40, 0, 0, 0, 1, 0, 0, 32'h20, 32'hDEADBEEF, 0};
    tbl[6]  = '{0, 0, 0,      0, 1, 0, 32'h40, 0, 0, 0, 0, 1, 0, 0,     32'hDEADBEEF, 0};
    tbl[7]  = '{0, 0, 0,      0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 32'h40, 32'hDEADBEEF, 0};
    tbl[8]  = '{0, 0, 0,      0, 0, 0, 0,     0, 0, 1, 0, 0, 1, 32'h40, 32'hDEADBEEF, 0};
    tbl[9]  = '{0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,     32'hDEADBEEF, 32'hA5A50040};
    tbl[10] = '{0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,     32'hDEADBEEF, 32'hA5A50040};

    #1;
    pipe_r_en = 1;
    repeat (3) cycle("reset");
    chk("reset.freeze_held_req", pipe_freeze, 0);
    chk("reset.mem_r_en", mem_r_en, 0);
    pipe_r_en = 0;
    rst = 1;

    // Pipe read, pipe write colliding with loader read, then the loader read.
    for (int i = 0; i < 11; i++) begin
      pipe_r_en = tbl[i].pr; pipe_w_en = tbl[i].pw;
      pipe_addr = tbl[i].pa; pipe_wdata = tbl[i].pd;
      ldr_req = tbl[i].lr; ldr_we = tbl[i].lw;
      ldr_addr = tbl[i].la; ldr_wdata = tbl[i].ld;
      @(negedge clk);
      chk($sformatf("vec%0d.freeze", i), pipe_freeze, tbl[i].e_frz);
      chk($sformatf("vec%0d.mem_r_en", i), mem_r_en, tbl[i].e_mr);
      chk($sformatf("vec%0d.mem_w_en", i), mem_w_en, tbl[i].e_mw);
      chk($sformatf("vec%0d.ldr_gnt", i), ldr_gnt, tbl[i].e_gnt);
      chk($sformatf("vec%0d.ldr_done", i), ldr_done, tbl[i].e_done);
      chk($sformatf("vec%0d.mem_addr", i), mem_addr, tbl[i].e_ma);
      chk($sformatf("vec%0d.pipe_rdata", i), pipe_rdata, tbl[i].e_prd);
      chk($sformatf("vec%0d.ldr_rdata", i), ldr_rdata, tbl[i].e_lrd);
      finish_cycle($sformatf("vec%0d", i));
    end

    // Reset while the loader owns the memory.
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h44;
    cycle("t5.gnt");
    ldr_req = 0;
    chk("t5.busy_mem_r_en", mem_r_en, 1);
    rst = 0;
    #1;
    chk("t5.rst_mem_r_en", mem_r_en, 0);
    chk("t5.rst_mem_w_en", mem_w_en, 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rst = 1;
      @(negedge clk);
      if (ldr_done) seen++;
      finish_cycle("t5.after");
    end
    chk("t5.no_ldr_done", seen, 0);

    // Reset in the middle of a pipe read, then the held request restarts from IDLE.
    pipe_r_en = 1; pipe_addr = 32'h30;
    cycle("t1.gnt");
    rst = 0;
    @(negedge clk);
    chk("t1.rst_freeze", pipe_freeze, 0);
    chk("t1.rst_mem_r_en", mem_r_en, 0);
    finish_cycle("t1.rst");
    rst = 1;
    @(negedge clk);
    chk("t1.idle_freeze", pipe_freeze, 1);
    chk("t1.idle_mem_r_en", mem_r_en, 0);
    finish_cycle("t1.idle");
    @(negedge clk);
    chk("t1.busy_mem_addr", mem_addr, 32'h30);
    finish_cycle("t1.busy");
    @(negedge clk);
    chk("t1.done_rdata", pipe_rdata, 32'hA5A50030);
    chk("t1.done_freeze", pipe_freeze, 0);
    finish_cycle("t1.done");
    pipe_r_en = 0;
    repeat (3) cycle("t1.tail");

    // Continuous pipe traffic with a loader waiting.
    pipe_r_en = 1; pipe_addr = 32'h80;
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h84; ldr_wdata = 32'h1234;
    first_gnt = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ldr_gnt && first_gnt < 0) first_gnt = i;
      finish_cycle("t6");
      if (first_gnt >= 0) ldr_req = 0;
    end
    chk("t6.first_ldr_gnt", first_gnt, FAIR ? 6 : -1);
    idle_inputs();
    repeat (4) cycle("t6.tail");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 249) != 0);
      pipe_r_en = ($urandom_range(0, 2) == 0);
      pipe_w_en = ($urandom_range(0, 3) == 0);
      pipe_addr = ($urandom_range(0, 3) == 0) ? 32'h10 : ($urandom() & 32'hFC);
      pipe_wdata = $urandom();
      if (m_last_gl) ldr_req = 0;
      if (!ldr_req && $urandom_range(0, 3) == 0) begin
        ldr_req = 1;
        ldr_we = $urandom_range(0, 1);
        ldr_addr = $urandom() & 32'hFFC;
        ldr_wdata = $urandom();
      end
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
